btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 7, number of button lines.
REQ-002 SHALL have parameter PRESCALE, default 16000, which sets the sample-tick period in clk cycles (1 ms at 16 MHz); legal range is 2..65535.
REQ-003 SHALL have parameter SAMPLES, default 8, the number of consecutive mismatching ticks needed to accept a change; legal range is 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-006 SHALL have port btn_in, input, WIDTH bits: raw asynchronous pad levels, active-low (0 = pressed).
REQ-007 SHALL have port irq_mask, input, WIDTH bits: per-button enable for irq.
REQ-008 SHALL have port irq_ack, input, 1 bit: one-cycle strobe that clears pending flags.
REQ-009 SHALL have port btn_out, output, WIDTH bits: debounced level, active-low, registered.
REQ-010 SHALL have port press_evt, output, WIDTH bits: one-cycle pulse per button on the debounced 1->0 transition.
REQ-011 SHALL have port pend, output, WIDTH bits: sticky press flags.
REQ-012 SHALL have port irq, output, 1 bit: the level interrupt request.

Function
REQ-013 SHALL pass each btn_in bit through a 2-flop synchronizer (sync) before any other use; the synchronizer reset value is 1.
REQ-014 SHALL implement the prescaler as follows:
- counter runs 0..PRESCALE-1 and wraps to 0;
- tick is high for exactly the one cycle where the counter equals PRESCALE-1.
REQ-015 SHALL keep, per bit, a count of width ceil(log2(SAMPLES+1)) that works as follows:
- sync == btn_out: count is cleared on every cycle, tick or not;
- sync != btn_out and tick and count < SAMPLES-1: count increments;
- sync != btn_out and tick and count == SAMPLES-1: btn_out takes sync on the next edge and count clears.
REQ-016 SHALL therefore accept a change only after SAMPLES consecutive mismatching ticks; any glitch that returns to the btn_out level between ticks restarts the count.
REQ-017 SHALL assert press_evt[i] in the same cycle btn_out[i] first reads 0 after reading 1; press_evt is registered and lasts exactly 1 cycle.
REQ-018 SHALL NOT generate press_evt on release (0->1).
REQ-019 SHALL set pend[i] in the cycle press_evt[i] is high; pend[i] holds until irq_ack.
REQ-020 SHALL clear all pend bits on irq_ack, except bits whose press_evt is high in that same cycle: set wins over clear.
REQ-021 SHALL drive irq = |(pend & irq_mask), combinational from registers; a change of irq_mask affects irq in the same cycle.
REQ-022 SHALL process all WIDTH bits independently; simultaneous transitions on several bits produce simultaneous press_evt bits.
REQ-023 SHALL have a total latency from a stable btn_in change to btn_out of 2 sync cycles plus SAMPLES ticks, bounded by 2 + SAMPLES*PRESCALE + 1 cycles.

Reset
REQ-024 SHALL, while rst = 0, asynchronously force:
- btn_out = all 1, sync flops = all 1;
- press_evt = 0, pend = 0, irq = 0;
- prescaler = 0, all counts = 0.
REQ-025 SHALL resume from the prescaler at 0 on the first edge after rst deasserts; a button held pressed through reset yields one press_evt after SAMPLES ticks.
REQ-026 SHALL discard any partially accumulated count when reset asserts mid-debounce.

Verification (PRESCALE=4, SAMPLES=3, WIDTH=7)
REQ-027 Clean press: btn_in[0] 1->0 held → btn_out[0]=0 within 2+12+1 cycles, a single-cycle press_evt[0], pend[0]=1, irq=1 with irq_mask=7'h01.
REQ-028 Bounce: btn_in[1] low for 2 ticks, high for 1 tick, repeated 5 times → btn_out[1] stays 1 and press_evt stays 0.
REQ-029 Release: from btn_out[0]=0, drive btn_in[0]=1 → btn_out[0]=1 after 3 ticks, press_evt=0, pend unchanged.
REQ-030 Ack race: irq_ack strobe in the same cycle as press_evt[2] with pend=7'h01 → pend=7'h04 and irq follows irq_mask.
REQ-031 Mask: pend=7'h08 with irq_mask=0 → irq=0; set irq_mask=7'h08 → irq=1 in the same cycle.
REQ-032 Reset mid-count: assert rst after 2 mismatching ticks, then release with btn_in still low → all outputs at reset values, then press_evt exactly once 3 ticks later.

Source files
------------

// File: rtl/btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce : per-line sampled debouncer with press events, sticky flags, irq
// Revision 1.0
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 16000,
  parameter int SAMPLES  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_evt,
  output logic [WIDTH-1:0] pend,
  output logic             irq
);

  localparam int c_pre_w = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int c_cnt_w = (SAMPLES > 1) ? $clog2(SAMPLES + 1) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);
  localparam logic [c_cnt_w-1:0] c_smp_max = c_cnt_w'(SAMPLES - 1);

  logic [WIDTH-1:0]              meta_q, meta_d;
  logic [WIDTH-1:0]              sync_q, sync_d;
  logic [c_pre_w-1:0]            presc_q, presc_d;
  logic [WIDTH-1:0][c_cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]              btn_out_q, btn_out_d;
  logic [WIDTH-1:0]              press_evt_q, press_evt_d;
  logic [WIDTH-1:0]              pend_q, pend_d;
  logic                          tick;

  always_comb begin
    meta_d    = btn_in;
    sync_d    = meta_q;
    tick      = (presc_q == c_pre_max);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    btn_out_d = btn_out_q;
    cnt_d     = cnt_q;
    // Any sample agreeing with the accepted level restarts that line's count.
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == btn_out_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == c_smp_max) begin
          btn_out_d[i] = sync_q[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_evt_d = btn_out_q & ~btn_out_d;
    // A press landing on the ack cycle survives the clear.
    pend_d      = (irq_ack ? '0 : pend_q) | press_evt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q      <= '1;
      sync_q      <= '1;
      presc_q     <= '0;
      cnt_q       <= '0;
      btn_out_q   <= '1;
      press_evt_q <= '0;
      pend_q      <= '0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      btn_out_q   <= btn_out_d;
      press_evt_q <= press_evt_d;
      pend_q      <= pend_d;
    end
  end

  assign btn_out   = btn_out_q;
  assign press_evt = press_evt_q;
  assign pend      = pend_q;
  assign irq       = |(pend_q & irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_debounce : directed scenarios plus random traffic against a reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_btn_debounce;
  localparam int W = 7;
  localparam int P = 4;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn_in;
  logic [W-1:0] irq_mask;
  logic         irq_ack;
  logic [W-1:0] btn_out, press_evt, pend;
  logic         irq;

  int errors = 0;
  int checks = 0;

  btn_debounce #(.WIDTH(W), .PRESCALE(P), .SAMPLES(S)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .irq_mask(irq_mask), .irq_ack(irq_ack),
    .btn_out(btn_out), .press_evt(press_evt), .pend(pend), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference: cycles-since-reset phase, two-stage input delay, and a run length
  // of consecutive mismatching ticks per line.
  int           m_pre = 0;
  int           m_run [W];
  logic [W-1:0] m_s1 = '1, m_s2 = '1, m_out = '1, m_evt = '0, m_pend = '0;
  logic [W-1:0] m_nout;
  logic         m_tk;
  logic         m_irq;
  assign m_irq = |(m_pend & irq_mask);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pre = 0; m_s1 = '1; m_s2 = '1; m_out = '1; m_evt = '0; m_pend = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_tk   = (m_pre == P - 1);
      m_pre  = (m_pre + 1) % P;
      m_nout = m_out;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_out[i]) m_run[i] = 0;
        else if (m_tk) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == S) begin
            m_nout[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end
      end
      m_pend = (irq_ack ? '0 : m_pend) | m_evt;
      m_evt  = m_out & ~m_nout;
      m_out  = m_nout;
      m_s2   = m_s1;
      m_s1   = btn_in;
    end
  end

  task automatic test_reset();
    rst = 1'b0; btn_in = '1; irq_mask = '0; irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    if ({btn_out, press_evt, pend, irq} !== {7'h7F, 7'h00, 7'h00, 1'b0}) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", {btn_out, press_evt, pend, irq}, {7'h7F, 7'h00, 7'h00, 1'b0});
    end
    checks++;
    btn_in = 7'h00; irq_mask = '1;
    repeat (20) @(negedge clk);
    if ({btn_out, press_evt, pend, irq} !== {7'h7F, 7'h00, 7'h00, 1'b0}) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", {btn_out, press_evt, pend, irq}, {7'h7F, 7'h00, 7'h00, 1'b0});
    end
    checks++;
    btn_in = '1; irq_mask = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int lat = -1;
    int nevt = 0;
    irq_mask = 7'h01;
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ({btn_out, press_evt, pend, irq} !== {m_out, m_evt, m_pend, m_irq}) begin
        errors++; $display("FAIL press_model k=%0d got=%h exp=%h", k, {btn_out, press_evt, pend, irq}, {m_out, m_evt, m_pend, m_irq});
      end
      checks++;
      if (press_evt[0] === 1'b1) nevt++;
      if (lat < 0 && btn_out[0] === 1'b0) lat = k;
    end
    if (lat < 11 || lat > 15) begin
      errors++; $display("FAIL press_latency got=%0d exp=11..15", lat);
    end
    checks++;
    if (nevt != 1) begin
      errors++; $display("FAIL press_evt_count got=%0d exp=1", nevt);
    end
    checks++;
    if ({pend, irq} !== {7'h01, 1'b1}) begin
      errors++; $display("FAIL press_pend_irq got=%h exp=%h", {pend, irq}, {7'h01, 1'b1});
    end
    checks++;
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3 * P; c++) begin
        btn_in[1] = (c < 2 * P) ? 1'b0 : 1'b1;
        @(negedge clk);
        if ({btn_out, press_evt, pend, irq} !== {m_out, m_evt, m_pend, m_irq}) begin
          errors++; $display("FAIL bounce_model r=%0d c=%0d got=%h exp=%h", r, c, {btn_out, press_evt, pend, irq}, {m_out, m_evt, m_pend, m_irq});
        end
        checks++;
        if (btn_out[1] !== 1'b1 || press_evt[1] !== 1'b0) bad++;
      end
    end
    if (bad != 0) begin
      errors++; $display("FAIL bounce_leak got=%0d bad cycles exp=0", bad);
    end
    checks++;
  endtask

  task automatic test_release();
    logic [W-1:0] pb = pend;
    int lat = -1;
    int nevt = 0;
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ({btn_out, press_evt, pend, irq} !== {m_out, m_evt, m_pend, m_irq}) begin
        errors++; $display("FAIL release_model k=%0d got=%h exp=%h", k, {btn_out, press_evt, pend, irq}, {m_out, m_evt, m_pend, m_irq});
      end
      checks++;
      if (press_evt !== 7'h00) nevt++;
      if (lat < 0 && btn_out[0] === 1'b1) lat = k;
    end
    if (lat < 11 || lat > 15) begin
      errors++; $display("FAIL release_latency got=%0d exp=11..15", lat);
    end
    checks++;
    if (nevt != 0 || pend !== pb) begin
      errors++; $display("FAIL release_side_effect evt=%0d pend=%h exp evt=0 pend=%h", nevt, pend, pb);
    end
    checks++;
  endtask

  task automatic test_ack_race();
    int k = 0;
    irq_mask = 7'h01;
    if (pend !== 7'h01) begin
      errors++; $display("FAIL ack_pre_pend got=%h exp=01", pend);
    end
    checks++;
    btn_in[2] = 1'b0;
    while (press_evt[2] !== 1'b1 && k < 25) begin
      @(negedge clk); k++;
    end
    if (k >= 25) begin
      errors++; $display("FAIL ack_wait_evt got=timeout exp=press_evt[2]");
    end
    checks++;
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    if ({pend, irq} !== {7'h04, 1'b0}) begin
      errors++; $display("FAIL ack_race_pend got=%h exp=%h", {pend, irq}, {7'h04, 1'b0});
    end
    checks++;
    if ({btn_out, press_evt, pend, irq} !== {m_out, m_evt, m_pend, m_irq}) begin
      errors++; $display("FAIL ack_model got=%h exp=%h", {btn_out, press_evt, pend, irq}, {m_out, m_evt, m_pend, m_irq});
    end
    checks++;
    irq_mask = 7'h04;
    #1;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL ack_irq_follow got=%b exp=1", irq);
    end
    checks++;
  endtask

  task automatic test_mask();
    int k = 0;
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    btn_in[3] = 1'b0;
    while (press_evt[3] !== 1'b1 && k < 25) begin
      @(negedge clk); k++;
    end
    if (k >= 25) begin
      errors++; $display("FAIL mask_wait_evt got=timeout exp=press_evt[3]");
    end
    checks++;
    @(negedge clk);
    irq_mask = 7'h00;
    #1;
    if ({pend, irq} !== {7'h08, 1'b0}) begin
      errors++; $display("FAIL mask_off got=%h exp=%h", {pend, irq}, {7'h08, 1'b0});
    end
    checks++;
    irq_mask = 7'h08;
    #1;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL mask_on got=%b exp=1", irq);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int nevt = 0;
    int first = -1;
    @(negedge clk);
    rst = 1'b0; btn_in = '1;
    repeat (2) @(negedge clk);
    rst = 1'b1; btn_in[4] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if ({btn_out, press_evt, pend, irq} !== {m_out, m_evt, m_pend, m_irq}) begin
        errors++; $display("FAIL midrst_model k=%0d got=%h exp=%h", k, {btn_out, press_evt, pend, irq}, {m_out, m_evt, m_pend, m_irq});
      end
      checks++;
    end
    #2 rst = 1'b0;
    #1;
    if ({btn_out, press_evt, pend, irq} !== {7'h7F, 7'h00, 7'h00, 1'b0}) begin
      errors++; $display("FAIL midrst_async got=%h exp=%h", {btn_out, press_evt, pend, irq}, {7'h7F, 7'h00, 7'h00, 1'b0});
    end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (press_evt[4] === 1'b1) begin
        nevt++;
        if (first < 0) first = k;
      end
    end
    if (nevt != 1 || first != 3 * P) begin
      errors++; $display("FAIL midrst_evt got count=%0d at=%0d exp count=1 at=%0d", nevt, first, 3 * P);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ({btn_out, press_evt, pend, irq} !== {m_out, m_evt, m_pend, m_irq}) begin
        errors++; $display("FAIL random_model k=%0d got=%h exp=%h", k, {btn_out, press_evt, pend, irq}, {m_out, m_evt, m_pend, m_irq});
      end
      checks++;
      rst = 1'b1;
      if ($urandom_range(0, 9) == 0) btn_in[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 4) == 0 && btn_in[1] == 1'b0) btn_in[1] = 1'b1;
      irq_ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) irq_mask = W'($urandom);
      if ($urandom_range(0, 799) == 0) rst = 1'b0;
    end
    rst = 1'b1; irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_ack_race();
    test_mask();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
